// File: rtl/bus_write_regs_pkg.sv
// Shared codes for the processor data bus: write destinations (same numbering
// as the bus read select) and bit positions of the increment/clear request vectors.
package bus_write_regs_pkg;

  localparam logic [3:0] WR_NONE = 4'd0;
  localparam logic [3:0] WR_DM   = 4'd1;
  localparam logic [3:0] WR_PC   = 4'd2;
  localparam logic [3:0] WR_DR   = 4'd3;
  localparam logic [3:0] WR_R    = 4'd4;
  localparam logic [3:0] WR_AC   = 4'd5;
  localparam logic [3:0] WR_TR   = 4'd6;
  localparam logic [3:0] WR_R1   = 4'd7;
  localparam logic [3:0] WR_R2   = 4'd8;
  localparam logic [3:0] WR_RI   = 4'd9;
  localparam logic [3:0] WR_RJ   = 4'd10;
  localparam logic [3:0] WR_RK   = 4'd11;

  localparam int INC_PC = 0;
  localparam int INC_RI = 1;
  localparam int INC_RJ = 2;
  localparam int INC_RK = 3;
  localparam int INC_AC = 4;

  localparam int CLR_AC = 0;
  localparam int CLR_RI = 1;
  localparam int CLR_RJ = 2;
  localparam int CLR_RK = 3;

endpackage

// File: rtl/bus_write_regs_if.sv
// Bus-side signals of the register write end: write/inc/clr requests in,
// architectural register contents and data-memory write strobe out.
interface bus_write_regs_if;
  logic [3:0]  write_en;
  logic [15:0] busin;
  logic [4:0]  inc_en;
  logic [3:0]  clr_en;

  logic [7:0]  pc, dr, r, r1, r2, ri, rj, rk;
  logic [15:0] ac, tr;
  logic        z;
  logic        dm_we;
  logic [7:0]  dm_wdata;

  modport master (
    output write_en, busin, inc_en, clr_en,
    input  pc, dr, r, r1, r2, ri, rj, rk, ac, tr, z, dm_we, dm_wdata
  );

  modport slave (
    input  write_en, busin, inc_en, clr_en,
    output pc, dr, r, r1, r2, ri, rj, rk, ac, tr, z, dm_we, dm_wdata
  );
endinterface

// File: rtl/bus_write_regs_gp_reg.sv
// General-purpose register with clear, load and increment; clear wins over
// load, load wins over increment, increment wraps modulo the width.
module bus_write_regs_gp_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             inc,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (ld) begin
      q_d = d;
    end else if (inc) begin
      q_d = q_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bus_write_regs.sv
// Write end of the 16-bit processor data bus: loads the selected register from
// the bus, drives the data-memory write strobe and keeps the AC zero flag.
module bus_write_regs
  import bus_write_regs_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  bus_write_regs_if.slave bus
);

  logic [15:0] ac_next;
  logic        z_d, z_q;
  logic        dm_we_d, dm_we_q;
  logic [7:0]  dm_wdata_d, dm_wdata_q;

  bus_write_regs_gp_reg #(.WIDTH(8)) u_pc (
    .clk(clk), .rst(rst), .ld(bus.write_en == WR_PC), .inc(bus.inc_en[INC_PC]),
    .clr(1'b0), .d(bus.busin[7:0]), .q(bus.pc));

  bus_write_regs_gp_reg #(.WIDTH(8)) u_dr (
    .clk(clk), .rst(rst), .ld(bus.write_en == WR_DR), .inc(1'b0),
    .clr(1'b0), .d(bus.busin[7:0]), .q(bus.dr));

  bus_write_regs_gp_reg #(.WIDTH(8)) u_r (
    .clk(clk), .rst(rst), .ld(bus.write_en == WR_R), .inc(1'b0),
    .clr(1'b0), .d(bus.busin[7:0]), .q(bus.r));

  bus_write_regs_gp_reg #(.WIDTH(16)) u_ac (
    .clk(clk), .rst(rst), .ld(bus.write_en == WR_AC), .inc(bus.inc_en[INC_AC]),
    .clr(bus.clr_en[CLR_AC]), .d(bus.busin), .q(bus.ac));

  bus_write_regs_gp_reg #(.WIDTH(16)) u_tr (
    .clk(clk), .rst(rst), .ld(bus.write_en == WR_TR), .inc(1'b0),
    .clr(1'b0), .d(bus.busin), .q(bus.tr));

  bus_write_regs_gp_reg #(.WIDTH(8)) u_r1 (
    .clk(clk), .rst(rst), .ld(bus.write_en == WR_R1), .inc(1'b0),
    .clr(1'b0), .d(bus.busin[7:0]), .q(bus.r1));

  bus_write_regs_gp_reg #(.WIDTH(8)) u_r2 (
    .clk(clk), .rst(rst), .ld(bus.write_en == WR_R2), .inc(1'b0),
    .clr(1'b0), .d(bus.busin[7:0]), .q(bus.r2));

  bus_write_regs_gp_reg #(.WIDTH(8)) u_ri (
    .clk(clk), .rst(rst), .ld(bus.write_en == WR_RI), .inc(bus.inc_en[INC_RI]),
    .clr(bus.clr_en[CLR_RI]), .d(bus.busin[7:0]), .q(bus.ri));

  bus_write_regs_gp_reg #(.WIDTH(8)) u_rj (
    .clk(clk), .rst(rst), .ld(bus.write_en == WR_RJ), .inc(bus.inc_en[INC_RJ]),
    .clr(bus.clr_en[CLR_RJ]), .d(bus.busin[7:0]), .q(bus.rj));

  bus_write_regs_gp_reg #(.WIDTH(8)) u_rk (
    .clk(clk), .rst(rst), .ld(bus.write_en == WR_RK), .inc(bus.inc_en[INC_RK]),
    .clr(bus.clr_en[CLR_RK]), .d(bus.busin[7:0]), .q(bus.rk));

  // z must flip in the same cycle AC changes, so it looks at AC's next value.
  always_comb begin
    ac_next = bus.ac;
    if (bus.clr_en[CLR_AC]) begin
      ac_next = '0;
    end else if (bus.write_en == WR_AC) begin
      ac_next = bus.busin;
    end else if (bus.inc_en[INC_AC]) begin
      ac_next = bus.ac + 16'd1;
    end
    z_d        = (ac_next == 16'd0);
    dm_we_d    = (bus.write_en == WR_DM);
    dm_wdata_d = dm_we_d ? bus.busin[7:0] : dm_wdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q        <= 1'b1;
      dm_we_q    <= 1'b0;
      dm_wdata_q <= 8'd0;
    end else begin
      z_q        <= z_d;
      dm_we_q    <= dm_we_d;
      dm_wdata_q <= dm_wdata_d;
    end
  end

  assign bus.z        = z_q;
  assign bus.dm_we    = dm_we_q;
  assign bus.dm_wdata = dm_wdata_q;

endmodule

// File: tb/tb_bus_write_regs.sv
// Bench for bus_write_regs: directed vector table, random traffic against an
// array-based reference model, and an asynchronous reset sequence.
module tb_bus_write_regs;

  logic clk;
  logic rst;

  bus_write_regs_if bif ();

  bus_write_regs dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  we;
    logic [15:0] bi;
    logic [4:0]  inc;
    logic [3:0]  clr;
    int          chk;
    logic [15:0] exp;
    logic        exp_z;
    logic        exp_dmwe;
  } vec_t;

  vec_t tbl[32];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: registers stored by write code (2..11), masked by width.
  int unsigned m_reg[16];
  int unsigned m_z;
  int unsigned m_dmwe;
  int unsigned m_dmw;

  function automatic int inc_bit(int code);
    case (code)
      2:       return 0;
      9:       return 1;
      10:      return 2;
      11:      return 3;
      5:       return 4;
      default: return -1;
    endcase
  endfunction

  function automatic int clr_bit(int code);
    case (code)
      5:       return 0;
      9:       return 1;
      10:      return 2;
      11:      return 3;
      default: return -1;
    endcase
  endfunction

  function automatic string reg_name(int code);
    case (code)
      2:       return "pc";
      3:       return "dr";
      4:       return "r";
      5:       return "ac";
      6:       return "tr";
      7:       return "r1";
      8:       return "r2";
      9:       return "ri";
      10:      return "rj";
      11:      return "rk";
      default: return "dm_wdata";
    endcase
  endfunction

  function automatic logic [15:0] dut_val(int code);
    case (code)
      2:       return {8'h00, bif.pc};
      3:       return {8'h00, bif.dr};
      4:       return {8'h00, bif.r};
      5:       return bif.ac;
      6:       return bif.tr;
      7:       return {8'h00, bif.r1};
      8:       return {8'h00, bif.r2};
      9:       return {8'h00, bif.ri};
      10:      return {8'h00, bif.rj};
      11:      return {8'h00, bif.rk};
      default: return {8'h00, bif.dm_wdata};
    endcase
  endfunction

  task automatic modelReset();
    for (int c = 0; c < 16; c++) m_reg[c] = 0;
    m_z    = 1;
    m_dmwe = 0;
    m_dmw  = 0;
  endtask

  task automatic modelStep(input logic [3:0] we, input logic [15:0] bi,
                           input logic [4:0] inc, input logic [3:0] clr);
    for (int c = 2; c <= 11; c++) begin
      int unsigned mask;
      int ib;
      int cb;
      mask = (c == 5 || c == 6) ? 32'hFFFF : 32'hFF;
      ib   = inc_bit(c);
      cb   = clr_bit(c);
      if (cb >= 0 && clr[cb]) m_reg[c] = 0;
      else if (int'(we) == c) m_reg[c] = 32'(bi) & mask;
      else if (ib >= 0 && inc[ib]) m_reg[c] = (m_reg[c] + 1) & mask;
    end
    m_dmwe = (we == 4'd1) ? 1 : 0;
    if (m_dmwe == 1) m_dmw = 32'(bi) & 32'hFF;
    m_z = (m_reg[5] == 0) ? 1 : 0;
  endtask

  // Drives one cycle of inputs, lets the edge happen and advances the model.
  task automatic applyStimulus(input logic [3:0] we, input logic [15:0] bi,
                               input logic [4:0] inc, input logic [3:0] clr);
    bif.write_en = we;
    bif.busin    = bi;
    bif.inc_en   = inc;
    bif.clr_en   = clr;
    @(posedge clk);
    modelStep(we, bi, inc, clr);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    for (int c = 2; c <= 11; c++)
      checkOutput($sformatf("%s/%s", tag, reg_name(c)), dut_val(c), 16'(m_reg[c]));
    checkOutput($sformatf("%s/z", tag), {15'd0, bif.z}, 16'(m_z));
    checkOutput($sformatf("%s/dm_we", tag), {15'd0, bif.dm_we}, 16'(m_dmwe));
    checkOutput($sformatf("%s/dm_wdata", tag), {8'h00, bif.dm_wdata}, 16'(m_dmw));
  endtask

  initial begin
    // Expected values below are worked out by hand from the register rules,
    // starting from the all-zero reset state.
    tbl[0]  = '{4'd2,  16'hA55A, 5'b00000, 4'b0000, 2,  16'h005A, 1'b1, 1'b0};
    tbl[1]  = '{4'd3,  16'hA55A, 5'b00000, 4'b0000, 3,  16'h005A, 1'b1, 1'b0};
    tbl[2]  = '{4'd4,  16'hA55A, 5'b00000, 4'b0000, 4,  16'h005A, 1'b1, 1'b0};
    tbl[3]  = '{4'd5,  16'hA55A, 5'b00000, 4'b0000, 5,  16'hA55A, 1'b0, 1'b0};
    tbl[4]  = '{4'd6,  16'hA55A, 5'b00000, 4'b0000, 6,  16'hA55A, 1'b0, 1'b0};
    tbl[5]  = '{4'd7,  16'hA55A, 5'b00000, 4'b0000, 7,  16'h005A, 1'b0, 1'b0};
    tbl[6]  = '{4'd8,  16'hA55A, 5'b00000, 4'b0000, 8,  16'h005A, 1'b0, 1'b0};
    tbl[7]  = '{4'd9,  16'hA55A, 5'b00000, 4'b0000, 9,  16'h005A, 1'b0, 1'b0};
    tbl[8]  = '{4'd10, 16'hA55A, 5'b00000, 4'b0000, 10, 16'h005A, 1'b0, 1'b0};
    tbl[9]  = '{4'd11, 16'hA55A, 5'b00000, 4'b0000, 11, 16'h005A, 1'b0, 1'b0};
    tbl[10] = '{4'd12, 16'hFFFF, 5'b00000, 4'b0000, 2,  16'h005A, 1'b0, 1'b0};
    tbl[11] = '{4'd13, 16'hFFFF, 5'b00000, 4'b0000, 5,  16'hA55A, 1'b0, 1'b0};
    tbl[12] = '{4'd14, 16'hFFFF, 5'b00000, 4'b0000, 6,  16'hA55A, 1'b0, 1'b0};
    tbl[13] = '{4'd15, 16'hFFFF, 5'b00000, 4'b0000, 11, 16'h005A, 1'b0, 1'b0};
    tbl[14] = '{4'd2,  16'h00FF, 5'b00000, 4'b0000, 2,  16'h00FF, 1'b0, 1'b0};
    tbl[15] = '{4'd0,  16'h0000, 5'b00001, 4'b0000, 2,  16'h0000, 1'b0, 1'b0};
    tbl[16] = '{4'd5,  16'hFFFF, 5'b00000, 4'b0000, 5,  16'hFFFF, 1'b0, 1'b0};
    tbl[17] = '{4'd0,  16'h0000, 5'b10000, 4'b0000, 5,  16'h0000, 1'b1, 1'b0};
    tbl[18] = '{4'd5,  16'h0010, 5'b00000, 4'b0001, 5,  16'h0000, 1'b1, 1'b0};
    tbl[19] = '{4'd9,  16'h0020, 5'b00010, 4'b0000, 9,  16'h0020, 1'b1, 1'b0};
    tbl[20] = '{4'd1,  16'h1234, 5'b00000, 4'b0000, 1,  16'h0034, 1'b1, 1'b1};
    tbl[21] = '{4'd1,  16'h5678, 5'b00000, 4'b0000, 1,  16'h0078, 1'b1, 1'b1};
    tbl[22] = '{4'd0,  16'h0000, 5'b00000, 4'b0000, 1,  16'h0078, 1'b1, 1'b0};
    tbl[23] = '{4'd9,  16'h0003, 5'b00000, 4'b0000, 9,  16'h0003, 1'b1, 1'b0};
    tbl[24] = '{4'd10, 16'h0007, 5'b00000, 4'b0000, 10, 16'h0007, 1'b1, 1'b0};
    tbl[25] = '{4'd11, 16'h00FF, 5'b00000, 4'b0000, 11, 16'h00FF, 1'b1, 1'b0};
    tbl[26] = '{4'd2,  16'h0009, 5'b00000, 4'b0000, 2,  16'h0009, 1'b1, 1'b0};
    tbl[27] = '{4'd0,  16'h0000, 5'b01111, 4'b0000, 9,  16'h0004, 1'b1, 1'b0};
    tbl[28] = '{4'd0,  16'h0000, 5'b00000, 4'b0000, 10, 16'h0008, 1'b1, 1'b0};
    tbl[29] = '{4'd0,  16'h0000, 5'b00000, 4'b0000, 11, 16'h0000, 1'b1, 1'b0};
    tbl[30] = '{4'd0,  16'h0000, 5'b00000, 4'b0010, 9,  16'h0000, 1'b1, 1'b0};
    tbl[31] = '{4'd10, 16'h0055, 5'b00100, 4'b0100, 10, 16'h0000, 1'b1, 1'b0};

    rst          = 1'b1;
    bif.write_en = 4'd0;
    bif.busin    = 16'd0;
    bif.inc_en   = 5'd0;
    bif.clr_en   = 4'd0;
    modelReset();

    #12;
    checkAll("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      applyStimulus(tbl[i].we, tbl[i].bi, tbl[i].inc, tbl[i].clr);
      checkOutput($sformatf("row%0d/%s", i, reg_name(tbl[i].chk)), dut_val(tbl[i].chk), tbl[i].exp);
      checkOutput($sformatf("row%0d/z", i), {15'd0, bif.z}, {15'd0, tbl[i].exp_z});
      checkOutput($sformatf("row%0d/dm_we", i), {15'd0, bif.dm_we}, {15'd0, tbl[i].exp_dmwe});
      checkAll($sformatf("row%0d", i));
    end

    // Random traffic; clears kept rare so registers get to accumulate values.
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  we;
      logic [15:0] bi;
      logic [4:0]  inc;
      logic [3:0]  clr;
      we  = 4'($urandom_range(0, 15));
      bi  = 16'($urandom);
      inc = 5'($urandom);
      clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
      if ($urandom_range(0, 15) == 0) bi = 16'h0000;
      applyStimulus(we, bi, inc, clr);
      checkAll($sformatf("rand%0d", i));
    end

    // Asynchronous reset in the middle of a cycle with a dm_we pulse in flight.
    applyStimulus(4'd5, 16'h1357, 5'd0, 4'd0);
    applyStimulus(4'd1, 16'h00C3, 5'd0, 4'd0);
    checkAll("pre_rst");
    bif.write_en = 4'd5;
    bif.busin    = 16'hFFFF;
    bif.inc_en   = 5'b11111;
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll("async_rst");
    @(posedge clk);
    #1;
    checkAll("rst_held");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'd2, 16'h0077, 5'd0, 4'd0);
    checkOutput("post_rst/pc", {8'h00, bif.pc}, 16'h0077);
    checkAll("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
